softmax_row_ctrl: RTL
=====================

SOFTMAX_ROW_CTRL -- requirements
Module: softmax_row_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning elements per row and width of the softmax datapath in lanes.
REQ-002 SHALL have parameter MAX_WAIT, default 64, meaning the cycle limit for a datapath response before timeout.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input element is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts an element.
REQ-007 SHALL have port in_data, input, 16 bits: element value, signed Q4.12.
REQ-008 SHALL have port sm_en, output, 1 bit: enable to the softmax datapath.
REQ-009 SHALL have port sm_valid_in, output, 1 bit: issue strobe to the datapath.
REQ-010 SHALL have port sm_in_x_flat, output, N*16 bits: row to the datapath; element k occupies bits [16k+15:16k].
REQ-011 SHALL have port sm_max_x, output, 16 bits: signed row maximum, Q4.12.
REQ-012 SHALL have port sm_valid_out, input, 1 bit: the datapath result is valid.
REQ-013 SHALL have port sm_prob_flat, input, N*16 bits: datapath probabilities, Q4.12, with the same lane order as sm_in_x_flat.
REQ-014 SHALL have port out_valid, output, 1 bit: a probability is presented.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer accepts a probability.
REQ-016 SHALL have port out_data, output, 16 bits: probability, Q4.12.
REQ-017 SHALL have port out_last, output, 1 bit: high with element N-1 of a row.
REQ-018 SHALL have port busy, output, 1 bit: high when the state is not COLLECT, or when the element count is non-zero.
REQ-019 SHALL have port err_timeout, output, 1 bit: sticky flag set when the datapath response times out.

Function
REQ-020 SHALL implement FSM states COLLECT, ISSUE, WAIT and DRAIN; reset state is COLLECT.
REQ-021 In COLLECT, in_ready SHALL be 1; an element is accepted when in_valid and in_ready are both 1; other states SHALL hold in_ready at 0.
REQ-022 An accepted element SHALL be stored in element register [idx], where idx counts 0..N-1.
REQ-023 The running maximum SHALL use a signed 16-bit compare; idx=0 loads the maximum unconditionally; on ties the value is unchanged.
REQ-024 Acceptance at idx=N-1 SHALL move to ISSUE on the next cycle and clear idx.
REQ-025 In ISSUE, sm_valid_in SHALL be 1 for exactly one cycle; the next state SHALL be WAIT.
REQ-026 sm_in_x_flat and sm_max_x SHALL be driven from registers, stable from ISSUE through the end of WAIT.
REQ-027 sm_en SHALL be 1 in ISSUE and WAIT, and 0 otherwise.
REQ-028 In WAIT, sm_valid_out=1 SHALL capture sm_prob_flat into a result register and move to DRAIN.
REQ-029 The wait counter SHALL count WAIT cycles starting at 1; if it reaches MAX_WAIT without sm_valid_out, the controller SHALL set err_timeout, discard the row and return to COLLECT.
REQ-030 err_timeout SHALL be cleared only by rst.
REQ-031 sm_valid_out in any state other than WAIT SHALL be ignored.
REQ-032 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal result lane k, where k counts 0..N-1.
REQ-033 k SHALL advance only when out_valid and out_ready are both 1.
REQ-034 out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-035 Handshake at k=N-1 SHALL return to COLLECT and clear k; the next input can be accepted on the following cycle.
REQ-036 Latency from the last input acceptance to sm_valid_in SHALL be 1 cycle.
REQ-037 Latency from the sm_valid_out capture edge to the first out_valid SHALL be 1 cycle.
REQ-038 All arithmetic SHALL be pure signed compares; no saturation and no rescaling of the data.

Reset
REQ-039 While rst is high, at the clock edge: state=COLLECT; idx, k and the wait counter = 0; max register = 16'h8000; element and result registers = 0.
REQ-040 Reset values of outputs SHALL be: in_ready=1 after reset releases; sm_en, sm_valid_in, out_valid, out_last, busy and err_timeout = 0; sm_in_x_flat, sm_max_x and out_data = 0.
REQ-041 rst in any state, including mid-WAIT or mid-DRAIN, SHALL abort the row with no further sm_valid_in or out_valid.

Verification
REQ-042 Inputs EC80, FE18, 2771, 15DB, one per cycle -> sm_max_x=2771; sm_in_x_flat=15DB_2771_FE18_EC80; one sm_valid_in pulse on the cycle after the 4th accept.
REQ-043 All-negative row 8000, 8001, FFFF, 8000 -> sm_max_x=FFFF; tie inputs 1000, 1000, 0800, 1000 -> sm_max_x=1000.
REQ-044 Model returns sm_prob_flat=0000_1000_0100_0010 after 5 cycles, with out_ready toggling 1,0,1,0 -> out_data sequence 0010, 0100, 1000, 0000 with no repeats or drops; out_last on 0000 only.
REQ-045 Model never asserts sm_valid_out -> err_timeout=1 after MAX_WAIT WAIT cycles; return to COLLECT; in_ready=1; the next row completes normally with err_timeout still 1.
REQ-046 rst asserted at k=2 in DRAIN -> the next cycle shows out_valid=0, busy=0, err_timeout=0; a fresh row behaves as in REQ-042.
REQ-047 in_valid gaps between elements, plus sm_valid_out pulsed during COLLECT -> elements stored in acceptance order; the stray pulse is ignored.

Source files
------------

// File: rtl/softmax_row_ctrl.sv
// Row controller for a softmax datapath: collects N Q4.12 elements with a running
// signed maximum, issues the row, waits (with timeout) for probabilities, drains them.
module softmax_row_ctrl #(
  parameter int N        = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  output logic            sm_en,
  output logic            sm_valid_in,
  output logic [N*16-1:0] sm_in_x_flat,
  output logic [15:0]     sm_max_x,
  input  logic            sm_valid_out,
  input  logic [N*16-1:0] sm_prob_flat,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic            out_last,
  output logic            busy,
  output logic            err_timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] k;
  logic [IW-1:0] k_nxt;
  logic [WW-1:0] wait_cnt;
  logic [15:0]   max_r;
  logic [15:0]   max_nxt;
  logic [15:0]   elem [N];
  logic [15:0]   res  [N];

  // First element of a row always seeds the maximum; ties keep the held value.
  always_comb begin
    max_nxt = max_r;
    if (idx == '0 || $signed(in_data) > $signed(max_r))
      max_nxt = in_data;
  end

  assign k_nxt = k + 1'b1;

  always_comb begin
    sm_in_x_flat = '0;
    for (int unsigned i = 0; i < N; i++)
      sm_in_x_flat[16*i +: 16] = elem[i];
  end

  assign in_ready = (state == COLLECT);
  assign busy     = (state != COLLECT) || (idx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= '0;
      k           <= '0;
      wait_cnt    <= '0;
      max_r       <= 16'h8000;
      for (int unsigned i = 0; i < N; i++) begin
        elem[i] <= '0;
        res[i]  <= '0;
      end
      sm_max_x    <= '0;
      sm_en       <= 1'b0;
      sm_valid_in <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      sm_valid_in <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (in_valid) begin
            elem[idx] <= in_data;
            max_r     <= max_nxt;
            if (idx == LAST_IDX) begin
              idx         <= '0;
              sm_max_x    <= max_nxt;
              sm_en       <= 1'b1;
              sm_valid_in <= 1'b1;
              state       <= ISSUE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= WW'(1);
          state    <= WAIT;
        end
        WAIT: begin
          if (sm_valid_out) begin
            for (int unsigned i = 0; i < N; i++)
              res[i] <= sm_prob_flat[16*i +: 16];
            sm_en     <= 1'b0;
            wait_cnt  <= '0;
            k         <= '0;
            out_valid <= 1'b1;
            out_data  <= sm_prob_flat[15:0];
            out_last  <= (N == 1);
            state     <= DRAIN;
          end else if (wait_cnt == WAIT_LIM) begin
            err_timeout <= 1'b1;
            sm_en       <= 1'b0;
            wait_cnt    <= '0;
            state       <= COLLECT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Presented lane only moves on a handshake, so a stalled consumer sees it held.
          if (out_ready) begin
            if (k == LAST_IDX) begin
              k         <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= COLLECT;
            end else begin
              k        <= k_nxt;
              out_data <= res[k_nxt];
              out_last <= (k_nxt == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
